// File: rtl/ef_smsdac_pkg.sv
// Shared types and constants for the segmented mismatch-shaping DAC blocks.
// Sequencer state codes are plain 2-bit constants so that older DAC modules can reuse them.
package ef_smsdac_pkg;

    typedef logic [1:0] state_t;
    typedef logic [7:0] sample_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_DRAIN  = 2'd3;

    localparam sample_t MIDSCALE_DEF = 8'h80;

endpackage

// File: rtl/ef_smsdac_seq_if.sv
// Host sample stream into the DAC sequencer (valid/ready, offset-binary samples).
interface ef_smsdac_seq_if;
    import ef_smsdac_pkg::*;

    sample_t i_data;
    logic    i_valid;
    logic    o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/ef_smsdac_fifo.sv
// Synchronous sample FIFO with registered occupancy; head is read combinationally.
// Push is dropped when full, pop is dropped when empty; there is no write-to-read bypass.
module ef_smsdac_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign o_full  = (level_q == LW'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push & ~o_full;
        do_pop   = i_pop & ~o_empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset: contents are only visible once level says they are valid.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ef_smsdac_seq.sv
// Sample scheduler and power-up sequencer for the 8-b mismatch-shaping DAC: one sample per
// (i_div+1) clocks onto o_x (registered, one cycle after the tick); host is held off when full or draining.
module ef_smsdac_seq
    import ef_smsdac_pkg::*;
#(
    parameter  int      DEPTH      = 4,
    parameter  int      DIV_W      = 8,
    parameter  int      SETTLE_CYC = 16,
    parameter  sample_t MIDSCALE   = MIDSCALE_DEF,
    localparam int      LW         = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_hold,
    ef_smsdac_seq_if.slave    host,
    output logic [7:0]        o_x,
    output logic              o_en_enc,
    output logic              o_en_dith,
    output logic              o_tick,
    output logic              o_busy,
    output logic              o_uflow,
    output logic [LW-1:0]     o_level
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    sample_t          x_q, x_d;
    sample_t          last_q, last_d;
    logic             tick_q, tick_d;
    logic             uflow_q, uflow_d;

    logic             active, tick, push, pop;
    logic             fifo_full, fifo_empty;
    sample_t          head;

    assign host.o_ready = ~fifo_full & (state_q != ST_DRAIN);
    assign push         = host.i_valid & host.o_ready;

    ef_smsdac_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_din   (host.i_data),
        .o_dout  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    always_comb begin
        active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        tick    = active && (cnt_q == '0);
        pop     = tick && !fifo_empty;
        state_d = state_q;
        scnt_d  = scnt_q;
        x_d     = x_q;
        last_d  = last_q;
        tick_d  = tick;
        uflow_d = uflow_q;

        // Outside RUN/DRAIN the counter tracks i_div so it holds a fresh period on entry.
        if (!active || tick) begin
            cnt_d = i_div;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        if (tick) begin
            if (!fifo_empty) begin
                x_d    = head;
                last_d = head;
            end else if (state_q == ST_RUN) begin
                uflow_d = 1'b1;
                x_d     = i_hold ? last_q : MIDSCALE;
            end else begin
                x_d = MIDSCALE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SETTLE;
                    scnt_d  = SW'(SETTLE_CYC - 1);
                    uflow_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end else if (scnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    scnt_d = scnt_q - SW'(1);
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tick && fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            scnt_q  <= '0;
            x_q     <= MIDSCALE;
            last_q  <= MIDSCALE;
            tick_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            x_q     <= x_d;
            last_q  <= last_d;
            tick_q  <= tick_d;
            uflow_q <= uflow_d;
        end
    end

    assign o_x       = x_q;
    assign o_tick    = tick_q;
    assign o_uflow   = uflow_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_en_enc  = o_busy;
    assign o_en_dith = o_busy;

endmodule

// File: tb/tb_ef_smsdac_seq.sv
// Randomised bench for ef_smsdac_seq against a queue-based behavioural model with a tick scoreboard.
module tb_ef_smsdac_seq;

    localparam int         DEPTH  = 4;
    localparam int         SETTLE = 16;
    localparam logic [7:0] MID    = 8'h80;

    logic       clk;
    logic       rst, start, stop, hold;
    logic [7:0] div;
    logic [7:0] o_x;
    logic       o_en_enc, o_en_dith, o_tick, o_busy, o_uflow;
    logic [2:0] o_level;

    ef_smsdac_seq_if bus();

    ef_smsdac_seq #(
        .DEPTH      (DEPTH),
        .DIV_W      (8),
        .SETTLE_CYC (SETTLE),
        .MIDSCALE   (MID)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_div     (div),
        .i_hold    (hold),
        .host      (bus),
        .o_x       (o_x),
        .o_en_enc  (o_en_enc),
        .o_en_dith (o_en_dith),
        .o_tick    (o_tick),
        .o_busy    (o_busy),
        .o_uflow   (o_uflow),
        .o_level   (o_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 settle, 2 run, 3 drain.
    int         m_mode;
    int         m_wait;
    int         m_settle;
    logic [7:0] m_q[$];
    logic [7:0] m_x, m_last;
    bit         m_tick, m_uflow;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_settle = 0;
        m_q.delete();
        m_x = MID; m_last = MID; m_tick = 0; m_uflow = 0;
    endtask

    task automatic model_step();
        bit ready, accept, fire;
        int nxt;
        if (rst) begin
            model_reset();
            return;
        end
        ready  = (m_q.size() < DEPTH) && (m_mode != 3);
        accept = bus.i_valid && ready;
        fire   = (m_mode >= 2) && (m_wait == 0);
        nxt    = m_mode;
        m_tick = fire;
        if (fire) begin
            if (m_q.size() > 0) begin
                m_x    = m_q.pop_front();
                m_last = m_x;
            end else if (m_mode == 2) begin
                m_uflow = 1;
                m_x     = hold ? m_last : MID;
            end else begin
                m_x = MID;
                nxt = 0;
            end
            exp_q.push_back(m_x);
        end
        if (m_mode >= 2) m_wait = fire ? int'(div) : m_wait - 1;
        else             m_wait = int'(div);
        case (m_mode)
            0: if (start) begin nxt = 1; m_settle = SETTLE; m_uflow = 0; end
            1: begin
                if (stop) nxt = 3;
                else begin
                    m_settle--;
                    if (m_settle == 0) nxt = 2;
                end
            end
            2: if (stop) nxt = 3;
            default: ;
        endcase
        if (accept) m_q.push_back(bus.i_data);
        m_mode = nxt;
    endtask

    task automatic check_outputs();
        chk("o_x",       int'(o_x),       int'(m_x));
        chk("o_tick",    int'(o_tick),    int'(m_tick));
        chk("o_uflow",   int'(o_uflow),   int'(m_uflow));
        chk("o_busy",    int'(o_busy),    int'(m_mode != 0));
        chk("o_en_enc",  int'(o_en_enc),  int'(m_mode != 0));
        chk("o_en_dith", int'(o_en_dith), int'(m_mode != 0));
        chk("o_level",   int'(o_level),   m_q.size());
        chk("o_ready",   int'(bus.o_ready), int'((m_q.size() < DEPTH) && (m_mode != 3)));
    endtask

    task automatic step(input bit r, input bit st, input bit sp, input bit v, input logic [7:0] d);
        rst = r; start = st; stop = sp;
        bus.i_valid = v; bus.i_data = d;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic run_until(input int mode, input int limit);
        int k = 0;
        while (m_mode != mode && k < limit) begin
            step(0, 0, 0, 0, 8'h00);
            k++;
        end
        chk("mode_reached_in_budget", int'(m_mode == mode), 1);
    endtask

    // Scoreboard monitor: every tick the DUT presents must match the next modelled sample.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (o_tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_tick", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_tick_x", int'(o_x), int'(e));
                end
            end
        end
    end

    initial begin
        logic [7:0] pre [4];
        pre[0] = 8'h10; pre[1] = 8'h20; pre[2] = 8'h30; pre[3] = 8'h40;
        div = 8'd3; hold = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        idle_steps(20);

        // Prefill in IDLE (fifth push refused), then start with period 4.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, pre[i]);
        step(0, 0, 0, 1, 8'h55);
        step(0, 1, 0, 0, 8'h00);
        idle_steps(SETTLE + 4 * 4 + 12);
        chk("uflow_hold_set", int'(o_uflow), 1);
        chk("hold_repeats_last", int'(o_x), 8'h40);
        step(0, 0, 1, 0, 8'h00);
        run_until(0, 40);

        // Underflow to midscale; start clears the sticky flag.
        hold = 1'b0;
        step(0, 1, 0, 0, 8'h00);
        chk("uflow_cleared_on_start", int'(o_uflow), 0);
        idle_steps(SETTLE + 12);
        step(0, 0, 1, 0, 8'h00);
        run_until(0, 40);

        // One sample per clock with continuous host pushes.
        div = 8'd0;
        step(0, 1, 0, 1, 8'($urandom));
        for (int i = 0; i < SETTLE + 30; i++) step(0, 0, 0, 1, 8'($urandom));
        chk("div0_no_uflow", int'(o_uflow), 0);
        step(0, 0, 1, 0, 8'h00);
        run_until(0, 40);

        // Stop with three samples queued in RUN.
        div = 8'd7;
        step(0, 1, 0, 0, 8'h00);
        run_until(2, 40);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'($urandom));
        step(0, 0, 1, 0, 8'h00);
        chk("ready_low_in_drain", int'(bus.o_ready), 0);
        run_until(0, 80);

        // Reset mid-RUN with FIFO partly full.
        div = 8'd5;
        step(0, 1, 0, 0, 8'h00);
        run_until(2, 40);
        step(0, 0, 0, 1, 8'hA1);
        step(0, 0, 0, 1, 8'hA2);
        step(1, 0, 0, 0, 8'h00);
        chk("rst_level_zero", int'(o_level), 0);
        chk("rst_x_mid", int'(o_x), int'(MID));

        // Start and stop together in IDLE: start wins; then stop during settle.
        step(0, 1, 1, 0, 8'h00);
        chk("start_wins_busy", int'(o_busy), 1);
        idle_steps(5);
        step(0, 0, 1, 0, 8'h00);
        run_until(0, 40);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 3));
            hold = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        step(1, 0, 0, 0, 8'h00);
        idle_steps(2);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
